// File: rtl/cache_mem_arbiter.sv
// Two-requester (icache/dcache) arbiter onto one SRAM-like memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is data-over-inst priority.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_dok,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_dok,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  // owner: 1 = data requester, 0 = instruction requester
  logic own_data;
  logic pick_data;
  logic grant;
  logic finish;

  assign grant  = (state == IDLE) && (inst_req || data_req);
  assign finish = (state == DATA) && mem_data_ok;
  assign mem_req = (state == ADDR);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  // on contention, the side that did not win last time goes first
  always_comb begin
    pick_data = 1'b0;
    unique case (1'b1)
      (data_req && !inst_req): pick_data = 1'b1;
      (data_req && inst_req):  pick_data = !last_grant;
      default:                 pick_data = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
    end else if (grant) begin
      last_grant <= pick_data;
    end
  end
`else
  always_comb begin
    pick_data = data_req;
  end
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (inst_req || data_req) state_nxt = ADDR;
      ADDR: if (mem_addr_ok) state_nxt = DATA;
      DATA: if (mem_data_ok) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      own_data  <= 1'b1;
      mem_wr    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant) begin
      own_data <= pick_data;
      if (pick_data) begin
        mem_wr    <= |data_wen;
        mem_wstrb <= data_wen;
        mem_addr  <= data_addr;
        mem_wdata <= data_wdata;
      end else begin
        mem_wr    <= 1'b0;
        mem_wstrb <= {STRB_W{1'b0}};
        mem_addr  <= inst_addr;
        mem_wdata <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_rdata <= '0;
      data_rdata <= '0;
      inst_dok   <= 1'b0;
      data_dok   <= 1'b0;
    end else begin
      inst_dok <= finish && !own_data;
      data_dok <= finish && own_data;
      if (finish && own_data) begin
        data_rdata <= mem_rdata;
      end
      if (finish && !own_data) begin
        inst_rdata <= mem_rdata;
      end
    end
  end

endmodule
